// File: rtl/lsu_mem_arb.sv
// Serialises the two LSU lanes of a bundle onto one shared data-memory port,
// lane 0 first, with one access outstanding and a response timeout.
module lsu_mem_arb #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  lane_req_i,
    input  logic [1:0]  lane_we_i,
    input  logic [3:0]  lane_size_i,
    input  logic [63:0] lane_addr_i,
    input  logic [63:0] lane_wdata_i,
    output logic        stall_o,
    output logic [63:0] lane_rdata_o,
    output logic [1:0]  lane_rvalid_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [1:0]  mem_size_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    state_e      state_q;
    logic [1:0]  pending_q;
    logic        cur_q;
    logic [7:0]  timer_q;
    logic        err_q;
    logic [63:0] laneRdata_q;
    logic [1:0]  laneRvalid_q;

    logic        curWe;
    logic        timedOut;
    logic        respValid;
    logic        otherPending;
    logic        issuing;
    logic [31:0] respData;

    always_comb begin
        curWe        = lane_we_i[cur_q];
        timedOut     = (state_q == WAIT) && !mem_rvalid_i && (timer_q == 8'(TIMEOUT - 1));
        respValid    = (state_q == WAIT) && (mem_rvalid_i || timedOut);
        otherPending = !cur_q && pending_q[1];
        issuing      = rst_ni && (state_q == ISSUE);
        respData     = timedOut ? 32'd0 : mem_rdata_i;

        // Lane fields are read live; upstream holds them while stalled.
        mem_req_o    = issuing;
        mem_we_o     = 1'b0;
        mem_size_o   = 2'b00;
        mem_addr_o   = 32'd0;
        mem_wdata_o  = 32'd0;
        if (issuing) begin
            mem_we_o    = curWe;
            mem_size_o  = cur_q ? lane_size_i[3:2]   : lane_size_i[1:0];
            mem_addr_o  = cur_q ? lane_addr_i[63:32]  : lane_addr_i[31:0];
            mem_wdata_o = cur_q ? lane_wdata_i[63:32] : lane_wdata_i[31:0];
        end

        stall_o = rst_ni && (((state_q == IDLE) && (lane_req_i != 2'b00)) ||
                             (state_q == ISSUE) ||
                             ((state_q == WAIT) && !(respValid && !otherPending)));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            pending_q    <= 2'b00;
            cur_q        <= 1'b0;
            timer_q      <= 8'd0;
            err_q        <= 1'b0;
            laneRdata_q  <= 64'd0;
            laneRvalid_q <= 2'b00;
        end else begin
            laneRvalid_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (lane_req_i != 2'b00) begin
                        pending_q <= lane_req_i;
                        cur_q     <= !lane_req_i[0];
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_gnt_i) begin
                        timer_q <= 8'd0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    timer_q <= timer_q + 8'd1;
                    if (respValid) begin
                        pending_q[cur_q]    <= 1'b0;
                        laneRvalid_q[cur_q] <= 1'b1;
                        // Stores complete without touching the lane's load data.
                        if (!curWe) begin
                            if (cur_q) laneRdata_q[63:32] <= respData;
                            else       laneRdata_q[31:0]  <= respData;
                        end
                        if (timedOut) err_q <= 1'b1;
                        if (otherPending) begin
                            cur_q   <= 1'b1;
                            state_q <= ISSUE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lane_rdata_o  = laneRdata_q;
    assign lane_rvalid_o = laneRvalid_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_lsu_mem_arb.sv
// Self-checking bench for lsu_mem_arb: cycle-exact scenario tasks plus a
// completion scoreboard fed when each bundle is driven.
module tb_lsu_mem_arb;

    logic        clk;
    logic        rst_n;
    logic [1:0]  laneReq;
    logic [1:0]  laneWe;
    logic [3:0]  laneSize;
    logic [63:0] laneAddr;
    logic [63:0] laneWdata;
    logic        stall;
    logic [63:0] laneRdata;
    logic [1:0]  laneRvalid;
    logic        memReq;
    logic        memWe;
    logic [1:0]  memSize;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        memGnt;
    logic        memRvalid;
    logic [31:0] memRdata;
    logic        err;

    int assertCount = 0;
    int failCount   = 0;

    logic [1:0]  expLaneQ[$];
    logic [63:0] expDataQ[$];
    logic [63:0] modelRdata = 64'd0;

    lsu_mem_arb #(.TIMEOUT(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .lane_req_i(laneReq), .lane_we_i(laneWe), .lane_size_i(laneSize),
        .lane_addr_i(laneAddr), .lane_wdata_i(laneWdata),
        .stall_o(stall), .lane_rdata_o(laneRdata), .lane_rvalid_o(laneRvalid),
        .mem_req_o(memReq), .mem_we_o(memWe), .mem_size_o(memSize),
        .mem_addr_o(memAddr), .mem_wdata_o(memWdata),
        .mem_gnt_i(memGnt), .mem_rvalid_i(memRvalid), .mem_rdata_i(memRdata),
        .err_o(err)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every lane completion must match the oldest expectation in the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && laneRvalid !== 2'b00) begin
            assertCount++;
            if (expLaneQ.size() == 0) begin
                failCount++;
                $display("[TB] FAIL unexpected_rvalid: got %b expected 00", laneRvalid);
            end else begin
                logic [1:0]  eLane;
                logic [63:0] eData;
                eLane = expLaneQ.pop_front();
                eData = expDataQ.pop_front();
                if (laneRvalid !== eLane || laneRdata !== eData) begin
                    failCount++;
                    $display("[TB] FAIL scoreboard: got rvalid %b rdata %h expected rvalid %b rdata %h",
                             laneRvalid, laneRdata, eLane, eData);
                end
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic midCycle();
        @(negedge clk);
    endtask

    task automatic expectLoad(input logic lane, input logic [31:0] data);
        if (lane) modelRdata[63:32] = data;
        else      modelRdata[31:0]  = data;
        expLaneQ.push_back(lane ? 2'b10 : 2'b01);
        expDataQ.push_back(modelRdata);
    endtask

    task automatic expectStore(input logic lane);
        expLaneQ.push_back(lane ? 2'b10 : 2'b01);
        expDataQ.push_back(modelRdata);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; laneReq = 2'b11; memGnt = 1'b1; memRvalid = 1'b1;
        nextCycle();
        midCycle();
        assertCount++; if (memReq !== 1'b0) begin failCount++; $display("[TB] FAIL reset_mem_req: got %b expected 0", memReq); end
        assertCount++; if (stall !== 1'b0) begin failCount++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
        assertCount++; if (laneRvalid !== 2'b00) begin failCount++; $display("[TB] FAIL reset_rvalid: got %b expected 00", laneRvalid); end
        assertCount++; if (laneRdata !== 64'd0) begin failCount++; $display("[TB] FAIL reset_rdata: got %h expected 0", laneRdata); end
        assertCount++; if (err !== 1'b0) begin failCount++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        nextCycle();
        laneReq = 2'b00; memGnt = 1'b0; memRvalid = 1'b0; rst_n = 1'b1;
        nextCycle();
    endtask

    task automatic test_single_load();
        laneReq = 2'b01; laneWe = 2'b00; laneSize = 4'b0010;
        laneAddr = {32'h0, 32'h100}; laneWdata = 64'd0;
        expectLoad(1'b0, 32'hDEADBEEF);
        midCycle();
        assertCount++; if (stall !== 1'b1) begin failCount++; $display("[TB] FAIL load_c0_stall: got %b expected 1", stall); end
        assertCount++; if (memReq !== 1'b0) begin failCount++; $display("[TB] FAIL load_c0_req: got %b expected 0", memReq); end
        nextCycle(); memGnt = 1'b1;
        midCycle();
        assertCount++; if (memReq !== 1'b1 || memAddr !== 32'h100 || memWe !== 1'b0 || memSize !== 2'b10)
            begin failCount++; $display("[TB] FAIL load_c1_issue: got req %b addr %h we %b size %b expected 1 100 0 10", memReq, memAddr, memWe, memSize); end
        assertCount++; if (stall !== 1'b1) begin failCount++; $display("[TB] FAIL load_c1_stall: got %b expected 1", stall); end
        nextCycle(); memGnt = 1'b0; memRvalid = 1'b1; memRdata = 32'hDEADBEEF;
        midCycle();
        assertCount++; if (stall !== 1'b0) begin failCount++; $display("[TB] FAIL load_c2_stall: got %b expected 0", stall); end
        assertCount++; if (memReq !== 1'b0 || memAddr !== 32'd0) begin failCount++; $display("[TB] FAIL load_c2_idle_fields: got req %b addr %h expected 0 0", memReq, memAddr); end
        nextCycle(); memRvalid = 1'b0; laneReq = 2'b00;
        midCycle();
        assertCount++; if (laneRvalid !== 2'b01 || laneRdata[31:0] !== 32'hDEADBEEF)
            begin failCount++; $display("[TB] FAIL load_c3_result: got %b %h expected 01 deadbeef", laneRvalid, laneRdata[31:0]); end
        nextCycle();
    endtask

    task automatic test_two_lanes();
        laneReq = 2'b11; laneWe = 2'b01; laneSize = 4'b1001;
        laneAddr = {32'h304, 32'h200}; laneWdata = {32'h77, 32'h11112222};
        memGnt = 1'b1;
        expectStore(1'b0);
        expectLoad(1'b1, 32'hCAFEF00D);
        midCycle();
        assertCount++; if (stall !== 1'b1 || memReq !== 1'b0) begin failCount++; $display("[TB] FAIL two_c0: got stall %b req %b expected 1 0", stall, memReq); end
        nextCycle();
        midCycle();
        assertCount++; if (memReq !== 1'b1 || memWe !== 1'b1 || memAddr !== 32'h200 || memWdata !== 32'h11112222 || memSize !== 2'b01)
            begin failCount++; $display("[TB] FAIL two_c1_lane0: got req %b we %b addr %h wdata %h size %b", memReq, memWe, memAddr, memWdata, memSize); end
        nextCycle(); memRvalid = 1'b1; memRdata = 32'h55555555;
        midCycle();
        assertCount++; if (stall !== 1'b1 || memReq !== 1'b0) begin failCount++; $display("[TB] FAIL two_c2: got stall %b req %b expected 1 0", stall, memReq); end
        nextCycle(); memRvalid = 1'b0;
        midCycle();
        assertCount++; if (memReq !== 1'b1 || memWe !== 1'b0 || memAddr !== 32'h304 || memWdata !== 32'h77 || memSize !== 2'b10)
            begin failCount++; $display("[TB] FAIL two_c3_lane1: got req %b we %b addr %h wdata %h size %b", memReq, memWe, memAddr, memWdata, memSize); end
        assertCount++; if (stall !== 1'b1 || laneRvalid !== 2'b01) begin failCount++; $display("[TB] FAIL two_c3: got stall %b rvalid %b expected 1 01", stall, laneRvalid); end
        nextCycle(); memRvalid = 1'b1; memRdata = 32'hCAFEF00D;
        midCycle();
        assertCount++; if (stall !== 1'b0) begin failCount++; $display("[TB] FAIL two_c4_stall: got %b expected 0", stall); end
        nextCycle(); memRvalid = 1'b0; memGnt = 1'b0; laneReq = 2'b00;
        midCycle();
        assertCount++; if (laneRvalid !== 2'b10) begin failCount++; $display("[TB] FAIL two_c5_rvalid: got %b expected 10", laneRvalid); end
        nextCycle();
    endtask

    task automatic test_gnt_stall();
        laneReq = 2'b10; laneWe = 2'b10; laneSize = 4'b1100;
        laneAddr = {32'h400, 32'h0}; laneWdata = {32'hA5A5A5A5, 32'h0};
        expectStore(1'b1);
        nextCycle();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) memGnt = 1'b1;
            midCycle();
            assertCount++;
            if (memReq !== 1'b1 || memWe !== 1'b1 || memAddr !== 32'h400 || memWdata !== 32'hA5A5A5A5 || memSize !== 2'b11 || stall !== 1'b1)
                begin failCount++; $display("[TB] FAIL gnt_hold_%0d: got req %b we %b addr %h wdata %h size %b stall %b", i, memReq, memWe, memAddr, memWdata, memSize, stall); end
            nextCycle();
        end
        memGnt = 1'b0; memRvalid = 1'b1; memRdata = 32'hFFFFFFFF;
        midCycle();
        assertCount++; if (stall !== 1'b0) begin failCount++; $display("[TB] FAIL gnt_done_stall: got %b expected 0", stall); end
        nextCycle(); memRvalid = 1'b0; laneReq = 2'b00;
        midCycle();
        assertCount++; if (laneRvalid !== 2'b10) begin failCount++; $display("[TB] FAIL gnt_rvalid: got %b expected 10", laneRvalid); end
        nextCycle();
    endtask

    task automatic test_timeout();
        laneReq = 2'b01; laneWe = 2'b00; laneSize = 4'b0010;
        laneAddr = {32'h0, 32'h500}; memGnt = 1'b1;
        expectLoad(1'b0, 32'd0);
        nextCycle();
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            midCycle();
            assertCount++;
            if (stall !== (i < 3) || err !== 1'b0)
                begin failCount++; $display("[TB] FAIL timeout_wait_%0d: got stall %b err %b expected %b 0", i, stall, err, i < 3); end
            nextCycle();
        end
        laneReq = 2'b10; laneWe = 2'b00; laneAddr = {32'h600, 32'h500};
        expectLoad(1'b1, 32'h13579BDF);
        midCycle();
        assertCount++; if (laneRvalid !== 2'b01 || laneRdata[31:0] !== 32'd0 || err !== 1'b1 || stall !== 1'b1)
            begin failCount++; $display("[TB] FAIL timeout_result: got rvalid %b rdata %h err %b stall %b expected 01 0 1 1", laneRvalid, laneRdata[31:0], err, stall); end
        nextCycle();
        nextCycle(); memGnt = 1'b0; memRvalid = 1'b1; memRdata = 32'h13579BDF;
        nextCycle(); memRvalid = 1'b0; laneReq = 2'b00;
        midCycle();
        assertCount++; if (laneRvalid !== 2'b10 || err !== 1'b1)
            begin failCount++; $display("[TB] FAIL timeout_sticky: got rvalid %b err %b expected 10 1", laneRvalid, err); end
        nextCycle();
    endtask

    task automatic test_reset_mid();
        laneReq = 2'b01; laneWe = 2'b00; laneAddr = {32'h0, 32'h700}; memGnt = 1'b1;
        nextCycle();
        nextCycle(); memGnt = 1'b0; rst_n = 1'b0;
        midCycle();
        assertCount++; if (memReq !== 1'b0 || stall !== 1'b0) begin failCount++; $display("[TB] FAIL rstmid_during: got req %b stall %b expected 0 0", memReq, stall); end
        nextCycle(); rst_n = 1'b1; laneReq = 2'b00; memRvalid = 1'b1; memRdata = 32'h99999999;
        modelRdata = 64'd0;
        midCycle();
        assertCount++; if (memReq !== 1'b0 || stall !== 1'b0 || err !== 1'b0 || laneRdata !== 64'd0)
            begin failCount++; $display("[TB] FAIL rstmid_after: got req %b stall %b err %b rdata %h expected 0 0 0 0", memReq, stall, err, laneRdata); end
        nextCycle(); memRvalid = 1'b0;
        midCycle();
        assertCount++; if (laneRvalid !== 2'b00 || memReq !== 1'b0) begin failCount++; $display("[TB] FAIL rstmid_late: got rvalid %b req %b expected 00 0", laneRvalid, memReq); end
        nextCycle();
    endtask

    task automatic test_idle();
        laneReq = 2'b00;
        for (int i = 0; i < 20; i++) begin
            laneWe = 2'($urandom); laneAddr = {$urandom, $urandom};
            memGnt = 1'($urandom); memRvalid = 1'($urandom); memRdata = $urandom;
            midCycle();
            assertCount++;
            if (stall !== 1'b0 || memReq !== 1'b0) begin failCount++; $display("[TB] FAIL idle_%0d: got stall %b req %b expected 0 0", i, stall, memReq); end
            nextCycle();
        end
        memGnt = 1'b0; memRvalid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; laneReq = 2'b00; laneWe = 2'b00; laneSize = 4'b0000;
        laneAddr = 64'd0; laneWdata = 64'd0;
        memGnt = 1'b0; memRvalid = 1'b0; memRdata = 32'd0;
        test_reset();
        test_single_load();
        test_two_lanes();
        test_gnt_stall();
        test_timeout();
        test_reset_mid();
        test_idle();
        nextCycle();
        assertCount++;
        if (expLaneQ.size() != 0) begin failCount++; $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expLaneQ.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/lsu_mem_arb.md
LSU_MEM_ARB -- requirements
Module: lsu_mem_arb

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum cycles to wait for mem_rvalid after a grant; legal range 2..255.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-low; sampled only on posedge clk.
REQ-004 lane_req  in  2  bit i high: LSU lane i has a memory access in the current bundle.
REQ-005 lane_we  in  2  bit i high: lane i access is a store; low: load.
REQ-006 lane_size  in  4  lane i access size at [2i+1:2i]; forwarded unmodified.
REQ-007 lane_addr  in  64  lane i byte address at [32i+31:32i].
REQ-008 lane_wdata  in  64  lane i store data at [32i+31:32i].
REQ-009 stall  out  1  freezes the LSU pipeline registers while the bundle's accesses are outstanding.
REQ-010 lane_rdata  out  64  lane i load data at [32i+31:32i], registered.
REQ-011 lane_rvalid  out  2  bit i high for one cycle: lane i access has completed.
REQ-012 mem_req, mem_we  out  1 each  single shared data-memory port request and write enable.
REQ-013 mem_size  out  2;  mem_addr  out  32;  mem_wdata  out  32  fields of the current memory request.
REQ-014 mem_gnt  in  1  memory accepts mem_req in this cycle.
REQ-015 mem_rvalid  in  1;  mem_rdata  in  32  response strobe (loads and stores) and load data.
REQ-016 err  out  1  sticky flag: a response timeout has occurred.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT; at most one memory access outstanding at any time.
REQ-018 IDLE with lane_req != 0: latch pending = lane_req; set cur = lowest set bit (lane 0 is older and always goes first); go to ISSUE.
REQ-019 ISSUE: mem_req = 1, with mem_we/size/addr/wdata taken from lane cur's input slice; on mem_gnt: go to WAIT, clear timer; otherwise hold all fields stable.
REQ-020 WAIT: mem_req = 0; timer increments each cycle.
REQ-021 WAIT with mem_rvalid: clear pending[cur]; next cycle lane_rvalid[cur] = 1.
REQ-022 WAIT with mem_rvalid on a load: lane_rdata[cur] <= mem_rdata.
REQ-023 WAIT with mem_rvalid on a store: lane_rdata[cur] stays unchanged.
REQ-024 After a WAIT response: if the other lane is still pending, set cur = 1 and go to ISSUE; otherwise go to IDLE.
REQ-025 WAIT timeout: timer reaches TIMEOUT-1 without mem_rvalid, so treat as a response with rdata = 0 and set err = 1 (sticky until reset).
REQ-026 stall = (IDLE and lane_req != 0) or ISSUE or (WAIT and not final completion); stall drops in the cycle the last pending access completes.
REQ-027 Lane inputs are held stable by the upstream pipeline while stall = 1; the block reads them live and latches only pending.
REQ-028 mem_rvalid outside WAIT is ignored; mem_gnt outside ISSUE is ignored.
REQ-029 When mem_req = 0: mem_we, mem_size, mem_addr and mem_wdata are driven 0.
REQ-030 The lane_rvalid of a completed bundle may coincide with the next bundle being accepted in IDLE; both are handled.

Reset
REQ-031 rst low at posedge: state = IDLE, pending = 0, timer = 0, err = 0, lane_rdata = 0, lane_rvalid = 0.
REQ-032 While rst is low, mem_req = 0 and stall = 0 regardless of other inputs.
REQ-033 Reset mid-transaction abandons the access; a late mem_rvalid arriving in IDLE is ignored.

Verification
REQ-034 Lane 0 load only, addr 0x100, gnt at c1, rvalid with rdata 0xDEADBEEF at c2 -> stall = 1 in c0..c1 and 0 in c2; lane_rvalid = 2'b01 and lane_rdata[31:0] = 0xDEADBEEF in c3.
REQ-035 Both lanes: lane 0 store, lane 1 load, immediate gnt, rvalid one cycle after gnt -> lane 0 issued at c1, lane 1 at c3; stall = 1 in c0..c3; lane_rvalid = 01 at c3 and 10 at c5.
REQ-036 mem_gnt withheld for 5 cycles -> mem_req and all mem fields stable for 6 cycles; stall = 1 throughout.
REQ-037 TIMEOUT = 4, no rvalid -> completion after 4 WAIT cycles, lane_rdata = 0, err = 1 and remaining high after further bundles.
REQ-038 rst low during WAIT, then mem_rvalid after release -> no lane_rvalid, state IDLE, mem_req = 0.
REQ-039 lane_req = 00 -> stall = 0, mem_req = 0 indefinitely.
